// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    // Booth pair {q_ext[0], q_m1} encodings that touch the accumulator
    localparam logic [1:0] BOOTH_SUB = 2'b10;
    localparam logic [1:0] BOOTH_ADD = 2'b01;

    // Step counter must hold WIDTH+1 after the final step
    function automatic int cnt_width(int w);
        return $clog2(w + 2);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: add/subtract then arithmetic shift.
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH+1:0] a,
    input  logic [WIDTH:0]   q_ext,
    input  logic             q_m1,
    input  logic [WIDTH:0]   m_ext,
    output logic [WIDTH+1:0] a_nxt,
    output logic [WIDTH:0]   q_ext_nxt,
    output logic             q_m1_nxt
);

    logic [WIDTH+1:0] m_sx;
    logic [WIDTH+1:0] a_sum;

    assign m_sx = {m_ext[WIDTH], m_ext};

    // Accumulator update selected by the current Booth pair
    always_comb begin
        a_sum = a;
        case ({q_ext[0], q_m1})
            BOOTH_SUB: a_sum = a - m_sx;
            BOOTH_ADD: a_sum = a + m_sx;
            default:   a_sum = a;
        endcase
    end

    // Arithmetic right shift of {a_sum, q_ext, q_m1}
    assign a_nxt     = {a_sum[WIDTH+1], a_sum[WIDTH+1:1]};
    assign q_ext_nxt = {a_sum[0], q_ext[WIDTH:1]};
    assign q_m1_nxt  = q_ext[0];

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-2 Booth multiplier, one step per clock, signed/unsigned
// per transaction, valid/ready on both sides.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH);

    state_t           state;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH+1:0] a;
    logic [WIDTH:0]   q_ext;
    logic             q_m1;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH+1:0] a_nxt;
    logic [WIDTH:0]   q_ext_nxt;
    logic             q_m1_nxt;

    // The extra top bit lets unsigned operands ride through signed Booth
    function automatic logic [WIDTH:0] extend(logic [WIDTH-1:0] v, logic sgn);
        return {sgn & v[WIDTH-1], v};
    endfunction

    booth_step #(.WIDTH(WIDTH)) u_step (
        .a         (a),
        .q_ext     (q_ext),
        .q_m1      (q_m1),
        .m_ext     (m_ext),
        .a_nxt     (a_nxt),
        .q_ext_nxt (q_ext_nxt),
        .q_m1_nxt  (q_m1_nxt)
    );

    // FSM, datapath registers and handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            product   <= '0;
            m_ext     <= '0;
            a         <= '0;
            q_ext     <= '0;
            q_m1      <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        m_ext    <= extend(multiplicand, is_signed);
                        q_ext    <= extend(multiplier, is_signed);
                        a        <= '0;
                        q_m1     <= 1'b0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    a     <= a_nxt;
                    q_ext <= q_ext_nxt;
                    q_m1  <= q_m1_nxt;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        product   <= {a_nxt[WIDTH-2:0], q_ext_nxt};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq at WIDTH=4 and WIDTH=8.
module tb_booth_mult_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       in_valid4 = 1'b0, is_signed4 = 1'b0, out_ready4 = 1'b0;
    logic [3:0] mcand4 = '0, mplier4 = '0;
    logic       in_ready4, out_valid4;
    logic [7:0] product4;

    logic        in_valid8 = 1'b0, is_signed8 = 1'b0, out_ready8 = 1'b0;
    logic [7:0]  mcand8 = '0, mplier8 = '0;
    logic        in_ready8, out_valid8;
    logic [15:0] product8;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    booth_mult_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .is_signed(is_signed4), .multiplicand(mcand4), .multiplier(mplier4),
        .out_valid(out_valid4), .out_ready(out_ready4), .product(product4)
    );

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .is_signed(is_signed8), .multiplicand(mcand8), .multiplier(mplier8),
        .out_valid(out_valid8), .out_ready(out_ready8), .product(product8)
    );

    // Drive operands, take the accept edge, drop in_valid.
    task automatic start4(input logic s, input logic [3:0] m, input logic [3:0] q);
        is_signed4 = s; mcand4 = m; mplier4 = q; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
    endtask

    task automatic start8(input logic s, input logic [7:0] m, input logic [7:0] q);
        is_signed8 = s; mcand8 = m; mplier8 = q; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    // Edges counted from the accept edge until out_valid; -1 on timeout.
    task automatic wait_done4(output int lat);
        lat = 0;
        while (!out_valid4 && lat < 100) begin @(posedge clk); #1; lat++; end
        if (!out_valid4) lat = -1;
    endtask

    task automatic wait_done8(output int lat);
        lat = 0;
        while (!out_valid8 && lat < 100) begin @(posedge clk); #1; lat++; end
        if (!out_valid8) lat = -1;
    endtask

    task automatic drain4;
        out_ready4 = 1'b1; @(posedge clk); #1; out_ready4 = 1'b0;
    endtask

    task automatic drain8;
        out_ready8 = 1'b1; @(posedge clk); #1; out_ready8 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({in_ready4, out_valid4, product4} !== {1'b1, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL reset4: rdy/vld/prod got %b/%b/%h want 1/0/00", in_ready4, out_valid4, product4);
        end
        vectors++;
        if ({in_ready8, out_valid8, product8} !== {1'b1, 1'b0, 16'h0000}) begin
            miscompares++;
            $display("FAIL reset8: rdy/vld/prod got %b/%b/%h want 1/0/0000", in_ready8, out_valid8, product8);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_w4_corners;
        int lat;
        start4(1'b1, 4'h8, 4'h8);
        wait_done4(lat);
        vectors++;
        if (lat !== 5) begin
            miscompares++;
            $display("FAIL w4_latency: got %0d edges want 5", lat);
        end
        vectors++;
        if (product4 !== 8'h40) begin
            miscompares++;
            $display("FAIL w4_min_x_min: got %h want 40", product4);
        end
        drain4();
        start4(1'b0, 4'hF, 4'hF);
        wait_done4(lat);
        vectors++;
        if (lat < 0 || product4 !== 8'hE1) begin
            miscompares++;
            $display("FAIL w4_unsigned_15x15: got %h lat %0d want E1", product4, lat);
        end
        drain4();
        start4(1'b1, 4'hF, 4'hF);
        wait_done4(lat);
        vectors++;
        if (lat < 0 || product4 !== 8'h01) begin
            miscompares++;
            $display("FAIL w4_signed_m1xm1: got %h lat %0d want 01", product4, lat);
        end
        drain4();
    endtask

    task automatic test_backpressure;
        int lat;
        start8(1'b1, 8'h80, 8'h7F);
        wait_done8(lat);
        vectors++;
        if (lat !== 9 || product8 !== 16'hC080) begin
            miscompares++;
            $display("FAIL bp_product: got %h lat %0d want C080 lat 9", product8, lat);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid8 = i[0];
            mcand8 = 8'(i + 3); mplier8 = 8'(i + 5); is_signed8 = ~i[1];
            @(posedge clk); #1;
            vectors++;
            if ({out_valid8, in_ready8, product8} !== {1'b1, 1'b0, 16'hC080}) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: vld/rdy/prod got %b/%b/%h want 1/0/C080", i, out_valid8, in_ready8, product8);
            end
        end
        in_valid8 = 1'b0;
        drain8();
        vectors++;
        if ({out_valid8, in_ready8} !== 2'b01) begin
            miscompares++;
            $display("FAIL bp_release: vld/rdy got %b/%b want 0/1", out_valid8, in_ready8);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        start8(1'b1, 8'h55, 8'hA3);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid8, in_ready8, product8} !== {1'b0, 1'b1, 16'h0000}) begin
            miscompares++;
            $display("FAIL reset_mid: vld/rdy/prod got %b/%b/%h want 0/1/0000", out_valid8, in_ready8, product8);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        start8(1'b1, 8'd3, 8'hFB);
        wait_done8(lat);
        vectors++;
        if (lat !== 9 || product8 !== 16'hFFF1) begin
            miscompares++;
            $display("FAIL after_reset_3xm5: got %h lat %0d want FFF1 lat 9", product8, lat);
        end
        drain8();
    endtask

    task automatic test_back_to_back;
        logic [7:0]  tm [3] = '{8'd200, 8'hF0, 8'd7};
        logic [7:0]  tq [3] = '{8'd150, 8'h0C, 8'hF9};
        logic        ts [3] = '{1'b0, 1'b1, 1'b1};
        logic [15:0] te [3] = '{16'h7530, 16'hFF40, 16'hFFCF};
        int acc [3];
        int lat, guard;
        out_ready8 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            is_signed8 = ts[k]; mcand8 = tm[k]; mplier8 = tq[k]; in_valid8 = 1'b1;
            guard = 0;
            while (!in_ready8 && guard < 50) begin @(posedge clk); #1; guard++; end
            @(posedge clk);
            acc[k] = cyc;
            #1;
            in_valid8 = 1'b0;
            is_signed8 = ~ts[k]; mcand8 = ~tm[k]; mplier8 = ~tq[k];
            wait_done8(lat);
            vectors++;
            if (lat !== 9 || product8 !== te[k]) begin
                miscompares++;
                $display("FAIL b2b[%0d]: got %h lat %0d want %h lat 9", k, product8, lat, te[k]);
            end
        end
        for (int k = 1; k < 3; k++) begin
            vectors++;
            if (acc[k] - acc[k-1] !== 11) begin
                miscompares++;
                $display("FAIL b2b_spacing[%0d]: got %0d cycles want 11", k, acc[k] - acc[k-1]);
            end
        end
        @(posedge clk); #1;
        out_ready8 = 1'b0;
    endtask

    task automatic test_exhaustive4;
        int lat, em, eq;
        logic [7:0] exp;
        for (int s = 0; s < 2; s++)
            for (int m = 0; m < 16; m++)
                for (int q = 0; q < 16; q++) begin
                    start4(s[0], m[3:0], q[3:0]);
                    wait_done4(lat);
                    em = (s == 1 && m >= 8) ? m - 16 : m;
                    eq = (s == 1 && q >= 8) ? q - 16 : q;
                    exp = 8'(em * eq);
                    vectors++;
                    if (lat !== 5 || product4 !== exp) begin
                        miscompares++;
                        $display("FAIL exh4 s%0d %0d*%0d: got %h lat %0d want %h", s, m, q, product4, lat, exp);
                    end
                    drain4();
                end
    endtask

    task automatic test_random8;
        int lat, m, q, s, em, eq;
        logic [15:0] exp;
        for (int i = 0; i < 300; i++) begin
            m = int'($urandom_range(0, 255));
            q = int'($urandom_range(0, 255));
            s = int'($urandom_range(0, 1));
            start8(s[0], m[7:0], q[7:0]);
            wait_done8(lat);
            em = (s == 1 && m >= 128) ? m - 256 : m;
            eq = (s == 1 && q >= 128) ? q - 256 : q;
            exp = 16'(em * eq);
            vectors++;
            if (lat !== 9 || product8 !== exp) begin
                miscompares++;
                $display("FAIL rand8 s%0d %0d*%0d: got %h lat %0d want %h", s, m, q, product8, lat, exp);
            end
            drain8();
        end
    endtask

    initial begin
        test_reset();
        test_w4_corners();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_exhaustive4();
        test_random8();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
